// File: rtl/block_pixel_fetch.sv
// Fetches one 8x8 pixel block from a planar YUV image in SRAM (two pixels per
// word, 2-cycle read latency) and writes it row-major into a dual-port RAM.
module block_pixel_fetch #(
  parameter logic [17:0] Y_BASE = 18'd0,
  parameter logic [17:0] U_BASE = 18'd38400,
  parameter logic [17:0] V_BASE = 18'd57600
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Start,
  input  logic [1:0]  Plane,
  input  logic [5:0]  Block_col,
  input  logic [4:0]  Block_row,
  output logic [17:0] SRAM_address,
  input  logic [15:0] SRAM_read_data,
  output logic        SRAM_we_n,
  output logic [6:0]  DP_address_a,
  output logic [6:0]  DP_address_b,
  output logic [31:0] DP_write_data_a,
  output logic [31:0] DP_write_data_b,
  output logic        DP_we,
  output logic        Busy,
  output logic        Done,
  output logic        Err
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t      state, state_next;
  logic [4:0]  cnt;         // READ: {r, k}; DRAIN: cycle index
  logic [1:0]  plane_q;
  logic [5:0]  col_q;
  logic [4:0]  row_q;
  logic [1:0]  valid_pipe;  // tracks addresses in flight through the SRAM
  logic [4:0]  wcnt;        // index of the next returned word
  logic        err_q;
  logic        legal;
  logic        accept;
  logic [17:0] base;
  logic [17:0] pitch;
  logic [17:0] line_off;
  logic [17:0] col_off;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    legal = 1'b1;
    if (Plane == 2'd3)                        legal = 1'b0;
    if (Block_row > 5'd29)                    legal = 1'b0;
    if (Plane == 2'd0 && Block_col > 6'd39)   legal = 1'b0;
    if (Plane != 2'd0 && Block_col > 6'd19)   legal = 1'b0;
  end

  assign accept = (state == IDLE) && Start && legal;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = READ;
      READ:    if (cnt == 5'd31) state_next = DRAIN;
      DRAIN:   if (cnt == 5'd1) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Word address of pixel row (8*row + r), word column (4*col + k).
  always_comb begin
    base  = V_BASE;
    pitch = 18'd80;
    case (plane_q)
      2'd0: begin base = Y_BASE; pitch = 18'd160; end
      2'd1: begin base = U_BASE; pitch = 18'd80;  end
      default: ;
    endcase
    line_off     = {10'd0, row_q, cnt[4:2]} * pitch;
    col_off      = {10'd0, col_q, cnt[1:0]};
    SRAM_address = '0;
    if (state == READ) SRAM_address = base + line_off + col_off;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state      <= IDLE;
      cnt        <= '0;
      plane_q    <= '0;
      col_q      <= '0;
      row_q      <= '0;
      valid_pipe <= '0;
      wcnt       <= '0;
      err_q      <= 1'b0;
    end else begin
      state      <= state_next;
      err_q      <= (state == IDLE) && Start && !legal;
      valid_pipe <= {valid_pipe[0], state == READ};
      if (accept) begin
        plane_q <= Plane;
        col_q   <= Block_col;
        row_q   <= Block_row;
        cnt     <= '0;
        wcnt    <= '0;
      end else begin
        // cnt wraps 31 -> 0 on leaving READ, so DRAIN counts from zero
        if (state == READ || state == DRAIN) cnt <= cnt + 5'd1;
        if (valid_pipe[1]) wcnt <= wcnt + 5'd1;
      end
    end
  end

  assign SRAM_we_n       = 1'b1;
  assign DP_we           = valid_pipe[1];
  assign DP_address_a    = DP_we ? {wcnt, 1'b0} : '0;
  assign DP_address_b    = DP_we ? {wcnt, 1'b1} : '0;
  assign DP_write_data_a = DP_we ? {24'd0, SRAM_read_data[15:8]} : '0;
  assign DP_write_data_b = DP_we ? {24'd0, SRAM_read_data[7:0]} : '0;
  assign Busy            = (state != IDLE);
  assign Done            = (state == DONE);
  assign Err             = err_q;

endmodule
